// File: rtl/lk_ans_top.sv
// -----------------------------------------------------------------------------
// lk_ans_top -- streaming 4-symbol rANS encoder/decoder (TinyTapeout tile).
//
// The host talks to the block through two 4-bit valid/ready streams carried on
// the tile pins. Commands: CFG loads the frequency table (M = 16), ENC encodes
// one symbol into the 12-bit encoder state, FLUSH emits the encoder state
// low-nibble first and rearms both coders, DEC pushes one nibble of the
// (host-reversed) stream into the 12-bit decoder state and emits symbols
// until the state drops back below 256.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   ena      in   tile enable, ignored
//   ui_in    in   [3:0] input nibble, [7:4] ignored
//   uio_in   in   [1:0] command, [2] in_vld, [3] out_rdy, [7:4] ignored
//   uo_out   out  [3:0] output nibble, [7:4] zero
//   uio_out  out  [4] in_rdy, [5] out_vld, other bits zero
//   uio_oe   out  constant 8'b0011_0000 (bits 4/5 are outputs)
// -----------------------------------------------------------------------------
module lk_ans_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENC_NORM, S_ENC_DIV, S_ENC_UPD, S_FLUSH_OUT, S_DEC_CHK, S_DEC_OUT
    } state_t;

    localparam logic [1:0] CMD_CFG   = 2'b00;
    localparam logic [1:0] CMD_ENC   = 2'b01;
    localparam logic [1:0] CMD_FLUSH = 2'b10;
    localparam logic [1:0] CMD_DEC   = 2'b11;

    // Pin decode
    logic [3:0] w_in_nib;
    logic [1:0] w_cmd;
    logic       w_in_vld;
    logic       w_out_rdy;
    logic       w_unused;

    assign w_in_nib  = ui_in[3:0];
    assign w_cmd     = uio_in[1:0];
    assign w_in_vld  = uio_in[2];
    assign w_out_rdy = uio_in[3];
    assign w_unused  = &{1'b0, ena, ui_in[7:4], uio_in[7:4]};

    state_t      r_state, r_state_nxt;
    logic [3:0]  r_f [4];          // frequency table
    logic [1:0]  r_ptr;            // CFG write pointer
    logic [11:0] r_xe;             // encoder state
    logic [11:0] r_xd;             // decoder state
    logic [1:0]  r_sym;            // symbol being encoded / decoded
    logic [11:0] r_quo;            // divider: dividend shifting out, quotient shifting in
    logic [3:0]  r_rem;            // divider: partial remainder (always < f_s)
    logic [3:0]  r_cnt;            // divider iteration count
    logic [1:0]  r_beat;           // FLUSH nibble index
    logic [3:0]  r_out;            // single-entry output register
    logic        r_out_vld;

    // Cumulative frequencies; 6 bits so an illegal table cannot wrap here.
    logic [5:0] w_cum [4];
    assign w_cum[0] = 6'd0;
    assign w_cum[1] = {2'b00, r_f[0]};
    assign w_cum[2] = w_cum[1] + {2'b00, r_f[1]};
    assign w_cum[3] = w_cum[2] + {2'b00, r_f[2]};

    logic       w_in_rdy, w_accept, w_out_free;
    logic [3:0] w_fs;
    logic [5:0] w_cs;

    assign w_in_rdy   = !rst && (r_state == S_IDLE) && !r_out_vld;
    assign w_accept   = w_in_vld && w_in_rdy;
    // The output register may be reloaded in the same cycle it is consumed.
    assign w_out_free = !r_out_vld || w_out_rdy;
    assign w_fs       = r_f[r_sym];
    assign w_cs       = w_cum[r_sym];

    // Encoder renormalisation: x_e >= f_s*256 means the update would overflow.
    logic        w_enc_emit;
    logic [11:0] w_xe_norm;
    assign w_enc_emit = (r_xe[11:8] >= w_fs);
    assign w_xe_norm  = w_enc_emit ? {4'h0, r_xe[11:4]} : r_xe;

    // One restoring-division step: bring in the next dividend bit.
    logic [4:0] w_rem_sh, w_rem_sub;
    logic       w_rem_ge;
    assign w_rem_sh  = {r_rem, r_quo[11]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, w_fs});
    assign w_rem_sub = w_rem_sh - {1'b0, w_fs};

    // Decoder: symbol lookup from the low nibble and state update.
    logic [3:0]  w_slot;
    logic [1:0]  w_dsym;
    logic [11:0] w_xd_next;
    assign w_slot = r_xd[3:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_dsym = 2'd0;
        if ({2'b00, w_slot} >= w_cum[1]) w_dsym = 2'd1;
        if ({2'b00, w_slot} >= w_cum[2]) w_dsym = 2'd2;
        if ({2'b00, w_slot} >= w_cum[3]) w_dsym = 2'd3;
    end

    assign w_xd_next = ({8'h00, w_fs} * {4'h0, r_xd[11:4]})
                     + {8'h00, w_slot} - {6'b00_0000, w_cs};

    logic [3:0] w_flush_nib;
    always_comb begin
        case (r_beat)
            2'd0:    w_flush_nib = r_xe[3:0];
            2'd1:    w_flush_nib = r_xe[7:4];
            default: w_flush_nib = r_xe[11:8];
        endcase
    end

    // Next-state and output-load strobe
    logic       w_load_out;
    logic [3:0] w_out_data;

    always_comb begin
        r_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_out_data  = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_cmd)
                        CMD_ENC:   r_state_nxt = S_ENC_NORM;
                        CMD_FLUSH: r_state_nxt = S_FLUSH_OUT;
                        CMD_DEC:   r_state_nxt = S_DEC_CHK;
                        default:   r_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_ENC_NORM: begin
                if (!w_enc_emit) begin
                    r_state_nxt = S_ENC_DIV;
                end else if (w_out_free) begin
                    w_load_out  = 1'b1;
                    w_out_data  = r_xe[3:0];
                    r_state_nxt = S_ENC_DIV;
                end
            end
            S_ENC_DIV: begin
                if (r_cnt == 4'd11) r_state_nxt = S_ENC_UPD;
            end
            S_ENC_UPD: r_state_nxt = S_IDLE;
            S_FLUSH_OUT: begin
                if (w_out_free) begin
                    w_load_out = 1'b1;
                    w_out_data = w_flush_nib;
                    if (r_beat == 2'd2) r_state_nxt = S_IDLE;
                end
            end
            S_DEC_CHK: begin
                r_state_nxt = (r_xd[11:8] != 4'h0) ? S_DEC_OUT : S_IDLE;
            end
            S_DEC_OUT: begin
                if (w_out_free) begin
                    w_load_out  = 1'b1;
                    w_out_data  = {2'b00, r_sym};
                    r_state_nxt = S_DEC_CHK;
                end
            end
            default: r_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // The table is only four entries, so it is reset like any register.
            for (int i = 0; i < 4; i++) r_f[i] <= 4'd4;
            r_ptr     <= 2'd0;
            r_xe      <= 12'd256;
            r_xd      <= 12'd0;
            r_sym     <= 2'd0;
            r_quo     <= 12'd0;
            r_rem     <= 4'd0;
            r_cnt     <= 4'd0;
            r_beat    <= 2'd0;
            r_out     <= 4'h0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out     <= w_out_data;
                r_out_vld <= 1'b1;
            end else if (w_out_rdy) begin
                r_out_vld <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_cmd)
                            CMD_CFG: begin
                                r_f[r_ptr] <= w_in_nib;
                                r_ptr      <= r_ptr + 2'd1;
                            end
                            CMD_ENC:   r_sym  <= w_in_nib[1:0];
                            CMD_FLUSH: r_beat <= 2'd0;
                            default:   r_xd   <= {r_xd[7:0], w_in_nib};
                        endcase
                    end
                end
                S_ENC_NORM: begin
                    if (!w_enc_emit || w_out_free) begin
                        r_xe  <= w_xe_norm;
                        r_quo <= w_xe_norm;
                        r_rem <= 4'd0;
                        r_cnt <= 4'd0;
                    end
                end
                S_ENC_DIV: begin
                    r_quo <= {r_quo[10:0], w_rem_ge};
                    r_rem <= w_rem_ge ? w_rem_sub[3:0] : w_rem_sh[3:0];
                    r_cnt <= r_cnt + 4'd1;
                end
                S_ENC_UPD: begin
                    r_xe <= {r_quo[7:0], 4'h0} + {8'h00, r_rem} + {6'b00_0000, w_cs};
                end
                S_FLUSH_OUT: begin
                    if (w_out_free) begin
                        if (r_beat == 2'd2) begin
                            r_xe   <= 12'd256;
                            r_xd   <= 12'd0;
                            r_ptr  <= 2'd0;
                            r_beat <= 2'd0;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                S_DEC_CHK: begin
                    if (r_xd[11:8] != 4'h0) r_sym <= w_dsym;
                end
                S_DEC_OUT: begin
                    if (w_out_free) r_xd <= w_xd_next;
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = {4'h0, rst ? 4'h0 : r_out};
    assign uio_out = {2'b00, r_out_vld & ~rst, w_in_rdy, 4'h0};
    assign uio_oe  = 8'b0011_0000;

endmodule

// File: tb/tb_lk_ans_top.sv
// -----------------------------------------------------------------------------
// tb_lk_ans_top -- directed bench for lk_ans_top. Expected output nibbles are
// queued when a command is issued; a monitor pops and compares each nibble
// as it is transferred on the output stream.
// -----------------------------------------------------------------------------
module tb_lk_ans_top;

    localparam logic [1:0] CMD_CFG   = 2'b00;
    localparam logic [1:0] CMD_ENC   = 2'b01;
    localparam logic [1:0] CMD_FLUSH = 2'b10;
    localparam logic [1:0] CMD_DEC   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [1:0] cmd = 2'b00;
    logic [3:0] din = 4'h0;
    logic       in_vld = 1'b0;
    logic       out_rdy = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    assign ui_in  = {4'h0, din};
    assign uio_in = {4'h0, out_rdy, in_vld, cmd};

    lk_ans_top dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a beat is transferred at the next rising edge when vld & rdy.
    always @(negedge clk) begin
        if (!rst && uio_out[5] && out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h expected none", uo_out[3:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_nibble", {28'h0, uo_out[3:0]}, {28'h0, mon_exp});
            end
        end
    end

    task automatic push(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] d);
        int n = 0;
        @(negedge clk);
        while (!uio_out[4] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("in_rdy_timeout", 32'd1, 32'd0);
        cmd    = c;
        din    = d;
        in_vld = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    // ENC and measure the cycles until the input stream is ready again.
    task automatic enc_timed(input logic [3:0] s);
        int n = 0;
        send(CMD_ENC, s);
        @(negedge clk);
        while (!uio_out[4] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("enc_rdy_within_16", {31'h0, (n + 1) <= 16}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !uio_out[4]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'h0, n >= 500}, 32'd0);
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!uio_out[5] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("vld_timeout", {31'h0, n >= 100}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", {31'h0, uio_out[4]}, 32'd0);
        check("rst_out_vld", {31'h0, uio_out[5]}, 32'd0);
        check("rst_out", {24'h0, uo_out}, 32'd0);
        check("uio_oe", {24'h0, uio_oe}, 32'h30);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_rdy_after_rst", {31'h0, uio_out[4]}, 32'd1);

        // Default table: ENC 1, FLUSH -> x_e = 0x404
        push(4'h4); push(4'h0); push(4'h4);
        enc_timed(4'd1);
        send(CMD_FLUSH, 4'h0);
        drain();

        // ENC 3, ENC 0 (emits C on renormalisation), FLUSH -> 0,0,1
        push(4'hC); push(4'h0); push(4'h0); push(4'h1);
        enc_timed(4'd3);
        enc_timed(4'd0);
        send(CMD_FLUSH, 4'h0);
        drain();

        // DEC 1,0,0,C -> 0 after the third nibble, then 3 and trailing 0
        push(4'h0); push(4'h3); push(4'h0);
        send(CMD_DEC, 4'h1);
        send(CMD_DEC, 4'h0);
        send(CMD_DEC, 4'h0);
        send(CMD_DEC, 4'hC);
        @(negedge clk);
        check("dec_in_rdy_low", {31'h0, uio_out[4]}, 32'd0);
        drain();

        // Fresh decoder via FLUSH (x_e = 256 -> 0,0,1)
        push(4'h0); push(4'h0); push(4'h1);
        send(CMD_FLUSH, 4'h0);
        drain();

        // DEC 4,0,4 -> 1, trailing 0; x_d = 64, so DEC 0 -> 0,0
        push(4'h1); push(4'h0);
        send(CMD_DEC, 4'h4);
        send(CMD_DEC, 4'h0);
        send(CMD_DEC, 4'h4);
        drain();
        push(4'h0); push(4'h0);
        send(CMD_DEC, 4'h0);
        drain();
        push(4'h0); push(4'h0); push(4'h1);
        send(CMD_FLUSH, 4'h0);
        drain();

        // Table 1,1,1,13; ENC 3 -> x_e = 0x13C; decode back
        send(CMD_CFG, 4'd1);
        @(negedge clk);
        check("cfg_in_rdy_high", {31'h0, uio_out[4]}, 32'd1);
        send(CMD_CFG, 4'd1);
        send(CMD_CFG, 4'd1);
        send(CMD_CFG, 4'd13);
        push(4'hC); push(4'h3); push(4'h1);
        enc_timed(4'd3);
        send(CMD_FLUSH, 4'h0);
        drain();
        push(4'h3); push(4'h0);
        send(CMD_DEC, 4'h1);
        send(CMD_DEC, 4'h3);
        send(CMD_DEC, 4'hC);
        drain();

        // Back-pressure during FLUSH (x_e = 256)
        out_rdy = 1'b0;
        push(4'h0); push(4'h0); push(4'h1);
        send(CMD_FLUSH, 4'h0);
        @(negedge clk);
        wait_vld();
        for (int i = 0; i < 20; i++) begin
            check("bp_vld_held", {31'h0, uio_out[5]}, 32'd1);
            check("bp_data_stable", {28'h0, uo_out[3:0]}, 32'd0);
            check("bp_in_rdy_low", {31'h0, uio_out[4]}, 32'd0);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        drain();

        // Reset mid-FLUSH drops the pending beat and restores the table
        out_rdy = 1'b0;
        send(CMD_FLUSH, 4'h0);
        @(negedge clk);
        wait_vld();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_vld_dropped", {31'h0, uio_out[5]}, 32'd0);
        check("midrst_in_rdy", {31'h0, uio_out[4]}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("midrst_out_vld_clear", {31'h0, uio_out[5]}, 32'd0);
        push(4'h4); push(4'h0); push(4'h4);
        enc_timed(4'd1);
        send(CMD_FLUSH, 4'h0);
        drain();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
